// File: rtl/adxl355_spi_rd_if.sv
// SPI pin bundle between the ADXL355 burst reader (master) and the sensor (slave).
interface adxl355_spi_rd_if;
    logic o_csn;
    logic o_sclk;
    logic o_mosi;
    logic i_miso;

    modport master (output o_csn, output o_sclk, output o_mosi, input i_miso);
    modport slave  (input o_csn, input o_sclk, input o_mosi, output i_miso);
endinterface

// File: rtl/adxl355_spi_rd.sv
// ADXL355 SPI mode-0 burst reader: on each i_sync rising edge reads X/Y/Z (and temperature
// when ADXL355_SPI_RD_TEMP_EN is defined) and presents them with a one-cycle o_valid strobe.
module adxl355_spi_rd #(
    parameter int unsigned clk_div = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_sync,
    adxl355_spi_rd_if.master  spi,
    output logic [19:0]       o_x,
    output logic [19:0]       o_y,
    output logic [19:0]       o_z,
    output logic [11:0]       o_temp,
    output logic              o_valid,
    output logic              o_overrun,
    output logic              o_busy
);

`ifdef ADXL355_SPI_RD_TEMP_EN
    localparam int unsigned NBYTES = 11;
    localparam logic [7:0]  CMD    = 8'h0D;
`else
    localparam int unsigned NBYTES = 9;
    localparam logic [7:0]  CMD    = 8'h11;
`endif
    localparam int unsigned DW     = 8 * NBYTES;
    localparam logic [6:0]  NBITS  = 7'(8 * (NBYTES + 1));
    localparam logic [8:0]  DIV_M1 = 9'(clk_div - 1);
    localparam logic [8:0]  GAP_M1 = 9'(2 * clk_div - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]    r_state;
    logic [8:0]    r_div;
    logic [6:0]    r_bit;
    logic [7:0]    r_cmd;
    logic [DW-1:0] r_shreg;
    logic          r_csn, r_sclk, r_mosi;
    logic          r_sync, r_sync_prev, r_armed;
    logic          w_rise;

    // r_armed stays low until i_sync has been seen at 0, so a level held through reset is not an edge
    assign w_rise = r_sync & ~r_sync_prev & r_armed;

    assign spi.o_csn  = r_csn;
    assign spi.o_sclk = r_sclk;
    assign spi.o_mosi = r_mosi;
    assign o_busy     = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_cmd       <= '0;
            r_shreg     <= '0;
            r_csn       <= 1'b1;
            r_sclk      <= 1'b0;
            r_mosi      <= 1'b0;
            r_sync      <= 1'b0;
            r_sync_prev <= 1'b0;
            r_armed     <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_z         <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef ADXL355_SPI_RD_TEMP_EN
            o_temp      <= '0;
`endif
        end else begin
            r_sync      <= i_sync;
            r_sync_prev <= r_sync;
            r_armed     <= r_armed | ~i_sync;
            o_valid     <= 1'b0;
            o_overrun   <= w_rise && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state <= SETUP;
                        r_csn   <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_mosi  <= CMD[7];
                        r_cmd   <= {CMD[6:0], 1'b0};
                    end
                end
                SETUP: begin
                    if (r_div == DIV_M1) begin
                        r_div   <= '0;
                        r_state <= SHIFT;
                    end else begin
                        r_div <= r_div + 9'd1;
                    end
                end
                SHIFT: begin
                    if (r_div == DIV_M1) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk  <= 1'b1;
                            r_bit   <= r_bit + 7'd1;
                            r_shreg <= {r_shreg[DW-2:0], spi.i_miso};
                        end else begin
                            // command bits drain out of r_cmd, leaving MOSI at 0 for the data phase
                            r_sclk <= 1'b0;
                            r_mosi <= r_cmd[7];
                            r_cmd  <= {r_cmd[6:0], 1'b0};
                            if (r_bit == NBITS)
                                r_state <= HOLD;
                        end
                    end else begin
                        r_div <= r_div + 9'd1;
                    end
                end
                HOLD: begin
                    if (r_div == DIV_M1) begin
                        r_div   <= '0;
                        r_csn   <= 1'b1;
                        r_state <= GAP;
                        o_valid <= 1'b1;
                        o_x     <= r_shreg[71:52];
                        o_y     <= r_shreg[47:28];
                        o_z     <= r_shreg[23:4];
`ifdef ADXL355_SPI_RD_TEMP_EN
                        o_temp  <= r_shreg[83:72];
`endif
                    end else begin
                        r_div <= r_div + 9'd1;
                    end
                end
                GAP: begin
                    if (r_div == GAP_M1) begin
                        r_div   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_div <= r_div + 9'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef ADXL355_SPI_RD_TEMP_EN
    assign o_temp = '0;
`endif

endmodule

// File: tb/tb_adxl355_spi_rd.sv
// Directed bench for adxl355_spi_rd with a mode-0 slave model; honours ADXL355_SPI_RD_TEMP_EN.
module tb_adxl355_spi_rd;

`ifdef ADXL355_SPI_RD_TEMP_EN
    localparam int         NB       = 11;
    localparam logic [7:0] EXP_CMD  = 8'h0D;
    localparam int         EXP_SCLK = 96;
    localparam int         EXP_LOW  = 776;
    localparam int         EXP_LAT  = 778;
    localparam logic [11:0] EXP_TEMP = 12'h79A;
`else
    localparam int         NB       = 9;
    localparam logic [7:0] EXP_CMD  = 8'h11;
    localparam int         EXP_SCLK = 80;
    localparam int         EXP_LOW  = 648;
    localparam int         EXP_LAT  = 650;
    localparam logic [11:0] EXP_TEMP = 12'h000;
`endif
    localparam int TW = 8 * (NB + 1);

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        sync = 1'b0;
    logic [19:0] x, y, z;
    logic [11:0] temp;
    logic        valid, ovr, busy;

    adxl355_spi_rd_if spi();

    adxl355_spi_rd #(.clk_div(4)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_sync    (sync),
        .spi       (spi),
        .o_x       (x),
        .o_y       (y),
        .o_z       (z),
        .o_temp    (temp),
        .o_valid   (valid),
        .o_overrun (ovr),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    // slave payload X3..Z1; command slot filled with junk the reader must discard
    logic [71:0]   acc_pl = 72'h0;
    logic [TW-1:0] tx     = '0;

    function automatic logic [TW-1:0] frame(input logic [71:0] acc);
`ifdef ADXL355_SPI_RD_TEMP_EN
        return {8'hA5, 8'h07, 8'h9A, acc};
`else
        return {8'hA5, acc};
`endif
    endfunction

    logic       sclk_q   = 1'b0;
    logic       win_open = 1'b0;
    logic [7:0] cmd_sh   = 8'h0;
    logic [7:0] last_cmd = 8'h0;
    int         sclk_cnt = 0, last_sclk = 0;
    int         low_cnt  = 0, last_low  = 0;
    int         n_valid  = 0, n_ovr     = 0;

    initial spi.i_miso = 1'b0;

    always @(posedge clk) begin
        sclk_q <= spi.o_sclk;
        if (valid) n_valid <= n_valid + 1;
        if (ovr)   n_ovr   <= n_ovr + 1;
        if (spi.o_csn) begin
            if (win_open) begin
                last_sclk <= sclk_cnt;
                last_cmd  <= cmd_sh;
                last_low  <= low_cnt;
                win_open  <= 1'b0;
            end
            sclk_cnt   <= 0;
            low_cnt    <= 0;
            tx         <= frame(acc_pl);
            spi.i_miso <= tx[TW-1];
        end else begin
            win_open <= 1'b1;
            low_cnt  <= low_cnt + 1;
            if (spi.o_sclk && !sclk_q) begin
                sclk_cnt <= sclk_cnt + 1;
                if (sclk_cnt < 8) cmd_sh <= {cmd_sh[6:0], spi.o_mosi};
            end
            if (sclk_q && !spi.o_sclk) begin
                tx         <= {tx[TW-2:0], 1'b0};
                spi.i_miso <= tx[TW-2];
            end
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 3000 && valid !== 1'b1) begin
            tick(1);
            n++;
        end
    endtask

    int lat;
    int busy_cyc;
    int guard;

    initial begin
        // reset values
        tick(3);
        chk("rst_csn", 32'(spi.o_csn), 32'd1);
        chk("rst_sclk", 32'(spi.o_sclk), 32'd0);
        chk("rst_mosi", 32'(spi.o_mosi), 32'd0);
        chk("rst_xyz", {12'h0, x | y | z}, 32'd0);
        chk("rst_temp", 32'(temp), 32'd0);
        chk("rst_strobes", {29'h0, valid, ovr, busy}, 32'd0);
        rstn = 1'b1;
        tick(3);

        // basic transfer
        acc_pl = 72'h123456_FFFFF7_800009;
        sync = 1'b1;
        wait_valid(lat);
        chk("A_latency", 32'(lat), 32'(EXP_LAT));
        chk("A_x", 32'(x), 32'h12345);
        chk("A_y", 32'(y), 32'hFFFFF);
        chk("A_z", 32'(z), 32'h80000);
        chk("A_temp", 32'(temp), 32'(EXP_TEMP));
        chk("A_busy_gap", 32'(busy), 32'd1);
        sync = 1'b0;
        tick(1);
        chk("A_valid_1cyc", 32'(valid), 32'd0);
        tick(20);
        chk("A_idle", 32'(busy), 32'd0);
        chk("A_cmd", 32'(last_cmd), 32'(EXP_CMD));
        chk("A_sclk", 32'(last_sclk), 32'(EXP_SCLK));
        chk("A_csn_low", 32'(last_low), 32'(EXP_LOW));
        chk("A_nvalid", 32'(n_valid), 32'd1);
        chk("A_novr", 32'(n_ovr), 32'd0);
        chk("A_hold_x", 32'(x), 32'h12345);

        // second sync edge 100 cycles into the transfer
        acc_pl = 72'hABCDEF_000010_7FFFF0;
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        tick(99);
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        wait_valid(lat);
        chk("B_latency", 32'(lat), 32'(EXP_LAT - 101));
        chk("B_x", 32'(x), 32'hABCDE);
        chk("B_y", 32'(y), 32'h00001);
        chk("B_z", 32'(z), 32'h7FFFF);
        tick(30);
        chk("B_novr", 32'(n_ovr), 32'd1);
        chk("B_nvalid", 32'(n_valid), 32'd2);
        chk("B_idle", 32'(busy), 32'd0);

        // periodic syncs, one per 1000 cycles
        for (int i = 0; i < 10; i++) begin
            acc_pl = {20'(i * 32'h11111), 4'h0, 24'h000100, 24'h000200};
            sync = 1'b1;
            tick(1);
            sync = 1'b0;
            tick(999);
            chk("C_sclk", 32'(last_sclk), 32'(EXP_SCLK));
            chk("C_x", 32'(x), 32'(i * 32'h11111));
        end
        chk("C_yz", {y, 12'h0} | 32'(z), 32'h00010020);
        chk("C_nvalid", 32'(n_valid), 32'd12);
        chk("C_novr", 32'(n_ovr), 32'd1);

        // reset during shift at bit 37
        acc_pl = 72'h123456_FFFFF7_800009;
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        guard = 0;
        while (guard < 2000 && sclk_cnt != 37) begin
            tick(1);
            guard++;
        end
        chk("D_reach_bit37", 32'(sclk_cnt), 32'd37);
        rstn = 1'b0;
        #1;
        chk("D_csn", 32'(spi.o_csn), 32'd1);
        chk("D_sclk", 32'(spi.o_sclk), 32'd0);
        chk("D_xyz", {12'h0, x | y | z}, 32'd0);
        chk("D_strobes", {29'h0, valid, ovr, busy}, 32'd0);
        tick(3);
        rstn = 1'b1;
        tick(700);
        chk("D_no_valid", 32'(n_valid), 32'd12);
        chk("D_x_cleared", 32'(x), 32'd0);
        sync = 1'b1;
        wait_valid(lat);
        chk("D_latency", 32'(lat), 32'(EXP_LAT));
        chk("D_x", 32'(x), 32'h12345);
        sync = 1'b0;
        tick(20);

        // i_sync held high across reset release
        rstn = 1'b0;
        sync = 1'b1;
        tick(3);
        rstn = 1'b1;
        busy_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (busy) busy_cyc++;
        end
        chk("E_no_start", 32'(busy_cyc), 32'd0);
        chk("E_csn", 32'(spi.o_csn), 32'd1);
        sync = 1'b0;
        tick(2);
        sync = 1'b1;
        wait_valid(lat);
        chk("E_latency", 32'(lat), 32'(EXP_LAT));
        chk("E_y", 32'(y), 32'hFFFFF);
        sync = 1'b0;
        tick(20);
        chk("E_nvalid", 32'(n_valid), 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/adxl355_spi_rd.md
ADXL355_SPI_RD -- requirements
Module: adxl355_spi_rd

Interface
REQ-001 Parameter clk_div, default 4: i_clk cycles per SCLK half-period (40 MHz / 8 = 5 MHz SCLK); legal 2..255.
REQ-002 i_clk  in  1  system clock; rising-edge only.
REQ-003 i_rstn  in  1  reset, asynchronous assert, active-low.
REQ-004 i_sync  in  1  sample trigger, synchronous to i_clk, rising-edge sensitive (same signal as drdy to ADXL355).
REQ-005 o_csn, o_sclk, o_mosi  out  1 each  SPI mode 0 master to ADXL355; i_miso  in  1.
REQ-006 o_x, o_y, o_z  out  20 each  signed two's complement acceleration, bits [23:4] of each 24-bit register triple.
REQ-007 o_temp  out  12  raw temperature; o_valid  out  1  one-cycle new-sample strobe; o_overrun  out  1  one-cycle strobe; o_busy  out  1.

Function
REQ-008 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP; o_busy SHALL be 1 in every state except IDLE.
REQ-009 A rising edge of i_sync (registered i_sync 1, previous 0) in IDLE SHALL move to SETUP and drive o_csn 0 on the next cycle.
REQ-010 A rising edge of i_sync outside IDLE SHALL be ignored for the transfer and pulse o_overrun for one cycle.
REQ-011 SETUP SHALL last clk_div cycles with o_sclk 0 and o_mosi holding command bit 7, then enter SHIFT.
REQ-012 Command byte SHALL be {start_addr[6:0],1'b1}; start_addr 0x08 (0x11 on wire), or 0x06 when TEMP enabled (0x0D).
REQ-013 SHIFT SHALL generate 8*(1+N) SCLK periods, N=9 data bytes (11 with TEMP); each period clk_div cycles low then clk_div cycles high.
REQ-014 o_mosi SHALL change only at SCLK falling edge, MSB first; after the command byte o_mosi SHALL be 0.
REQ-015 i_miso SHALL be sampled on the i_clk cycle o_sclk goes 1; command-byte bits discarded.
REQ-016 Bit counter SHALL be 7 bits wide and SHIFT SHALL exit after exactly 8*(1+N) rising SCLK edges, leaving o_sclk 0.
REQ-017 HOLD SHALL keep o_csn 0, o_sclk 0 for clk_div cycles, then drive o_csn 1 and enter GAP.
REQ-018 On the HOLD->GAP transition o_x/o_y/o_z (and o_temp) SHALL update simultaneously and o_valid SHALL pulse 1 for exactly one cycle.
REQ-019 Byte order SHALL be X3,X2,X1,Y3,Y2,Y1,Z3,Z2,Z1; o_x = {X3,X2,X1[7:4]}; likewise Y, Z; outputs hold between strobes.
REQ-020 GAP SHALL keep o_csn 1 for 2*clk_div cycles, then enter IDLE; a sync edge in GAP counts as overrun.
REQ-021 With clk_div=4, TEMP off: o_csn low duration SHALL be 4+80*8+4 = 648 cycles; sync-to-o_valid latency 650 cycles.

Reset
REQ-022 While i_rstn=0: state IDLE, o_csn 1, o_sclk 0, o_mosi 0, o_x/o_y/o_z/o_temp 0, o_valid 0, o_overrun 0, o_busy 0, sync edge register 0.
REQ-023 Reset asserted mid-transfer SHALL abort immediately with o_csn 1 and no o_valid; data outputs cleared to 0.
REQ-024 i_sync held 1 through reset release SHALL NOT start a transfer (edge detector cleared to 1-sampled only after first cycle with i_sync 0).

Configuration
REQ-025 Macro ADXL355_SPI_RD_TEMP_EN defined: start address 0x06, N=11, bytes T2,T1 precede X3; o_temp = {T2[3:0],T1}.
REQ-026 Macro ADXL355_SPI_RD_TEMP_EN undefined: start address 0x08, N=9, o_temp tied to 0, no temperature logic.

Verification
REQ-027 clk_div=4, TEMP off, slave model returns X=0x12345_x,Y=0xFFFFF_x,Z=0x80000_x -> wire command 0x11, o_x=0x12345, o_y=0xFFFFF (-1), o_z=0x80000, one o_valid 650 cycles after sync edge.
REQ-028 Second sync edge 100 cycles after first -> o_overrun pulse once, single transfer, single o_valid.
REQ-029 Sync pulses every 1000 cycles (1 kHz at 1 MHz equivalent) for 10 periods -> 10 transfers, 10 o_valid, no overrun, SCLK count 80 per csn window.
REQ-030 i_rstn low at bit 37 of SHIFT -> o_csn 1 same cycle, no o_valid, outputs 0; next sync completes normally.
REQ-031 TEMP_EN defined, T2=0x07,T1=0x9A -> command 0x0D, 96 SCLK edges, o_temp=0x79A.
REQ-032 i_sync held high across reset release -> no transfer until a 0->1 transition.
